// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath controller: state codes, instruction
// fields, datapath select codes and the one-hot instruction class.
package datapath_ctrl_pkg;

  localparam int SW_DEF = 4;

  typedef enum logic [3:0] {
    ST_WAIT   = 4'd0,
    ST_DECODE = 4'd1,
    ST_GET_A  = 4'd2,
    ST_GET_B  = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MOVB   = 4'd5,
    ST_CMPS   = 4'd6,
    ST_WR_REG = 4'd7,
    ST_WR_IMM = 4'd8,
    ST_SPARE  = 4'd9
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef struct packed {
    logic movi;
    logic mov;
    logic alu3;
    logic cmp;
    logic mvn;
    logic illegal;
  } cls_t;

endpackage

// File: rtl/datapath_ctrl_if.sv
// Instruction-side start/opcode inputs and all datapath strobes of the controller.
interface datapath_ctrl_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] alu_op;

  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op
  );
endinterface

// File: rtl/datapath_ctrl_decode.sv
// Combinational map from the latched {opcode, op} to a one-hot instruction class.
module ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    unique case ({opcode, op})
      {OPC_MOV, OP_MOVI}: cls.movi = 1'b1;
      {OPC_MOV, OP_MOV}:  cls.mov  = 1'b1;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_AND}:  cls.alu3 = 1'b1;
      {OPC_ALU, OP_CMP}:  cls.cmp  = 1'b1;
      {OPC_ALU, OP_MVN}:  cls.mvn  = 1'b1;
      default:            cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing register reads, ALU op and write-back.
// Outputs decode from the state register and the opcode/op latched on start.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int SW = SW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  datapath_ctrl_if.slave bus
);

  logic [SW-1:0] state;
  logic [2:0]    opcode_q;
  logic [1:0]    op_q;
  cls_t          cls;
  state_t        cur;

  assign cur = state_t'(state);

  ctrl_decode u_decode (
    .opcode (opcode_q),
    .op     (op_q),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SW'(ST_WAIT);
      opcode_q <= '0;
      op_q     <= '0;
    end else begin
      case (cur)
        ST_WAIT: begin
          if (bus.s) begin
            state    <= SW'(ST_DECODE);
            opcode_q <= bus.opcode;
            op_q     <= bus.op;
          end
        end
        ST_DECODE: begin
          if (cls.movi)                state <= SW'(ST_WR_IMM);
          else if (cls.mov || cls.mvn) state <= SW'(ST_GET_B);
          else if (cls.alu3 || cls.cmp) state <= SW'(ST_GET_A);
          else                         state <= SW'(ST_WAIT);
        end
        ST_GET_A: state <= SW'(ST_GET_B);
        ST_GET_B: begin
          if (cls.mov)      state <= SW'(ST_MOVB);
          else if (cls.cmp) state <= SW'(ST_CMPS);
          else              state <= SW'(ST_EXEC);
        end
        ST_EXEC:   state <= SW'(ST_WR_REG);
        ST_MOVB:   state <= SW'(ST_WR_REG);
        ST_CMPS:   state <= SW'(ST_WAIT);
        ST_WR_REG: state <= SW'(ST_WAIT);
        ST_WR_IMM: state <= SW'(ST_WAIT);
        // spare slot and unused encodings recover to idle
        default:   state <= SW'(ST_WAIT);
      endcase
    end
  end

  always_comb begin
    bus.w      = 1'b0;
    bus.nsel   = NSEL_NONE;
    bus.vsel   = VSEL_C;
    bus.write  = 1'b0;
    bus.loada  = 1'b0;
    bus.loadb  = 1'b0;
    bus.loadc  = 1'b0;
    bus.loads  = 1'b0;
    bus.asel   = 1'b0;
    bus.bsel   = 1'b0;
    bus.alu_op = ALU_ADD;
    case (cur)
      ST_WAIT: bus.w = 1'b1;
      ST_GET_A: begin
        bus.nsel  = NSEL_RN;
        bus.loada = 1'b1;
      end
      ST_GET_B: begin
        bus.nsel  = NSEL_RM;
        bus.loadb = 1'b1;
      end
      ST_EXEC: begin
        bus.alu_op = op_q;
        bus.loadc  = 1'b1;
        bus.asel   = cls.mvn;
      end
      ST_MOVB: begin
        bus.asel   = 1'b1;
        bus.alu_op = ALU_ADD;
        bus.loadc  = 1'b1;
      end
      ST_CMPS: begin
        bus.alu_op = ALU_SUB;
        bus.loads  = 1'b1;
      end
      ST_WR_REG: begin
        bus.nsel  = NSEL_RD;
        bus.vsel  = VSEL_C;
        bus.write = 1'b1;
      end
      ST_WR_IMM: begin
        bus.nsel  = NSEL_RN;
        bus.vsel  = VSEL_IMM;
        bus.write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench: per-cycle expected strobe vectors queued at issue, compared each negedge.
module tb_datapath_ctrl;

  logic clk = 1'b0;
  logic reset;

  datapath_ctrl_if bus();

  datapath_ctrl #(.SW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [14:0] exp_q[$];

  // {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op}
  function automatic logic [14:0] mk(input bit w, input logic [2:0] nsel, input logic [1:0] vsel,
                                     input bit wr, input bit la, input bit lb, input bit lc,
                                     input bit ls, input bit asel, input logic [1:0] alu);
    return {w, nsel, vsel, wr, la, lb, lc, ls, asel, 1'b0, alu};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.w, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.alu_op};
  endfunction

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  logic [14:0] v_wait, v_dec, v_geta, v_getb, v_movb, v_cmps, v_wrreg, v_wrimm;

  initial begin
    v_wait  = mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    v_dec   = mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    v_geta  = mk(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00);
    v_getb  = mk(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00);
    v_movb  = mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00);
    v_cmps  = mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01);
    v_wrreg = mk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00);
    v_wrimm = mk(0, 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00);
  end

  task automatic push_seq(input logic [2:0] opc, input logic [1:0] op);
    exp_q.push_back(v_dec);
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(v_wrimm);
    end else if (opc == 3'b110 && op == 2'b00) begin
      exp_q.push_back(v_getb);
      exp_q.push_back(v_movb);
      exp_q.push_back(v_wrreg);
    end else if (opc == 3'b101 && (op == 2'b00 || op == 2'b10)) begin
      exp_q.push_back(v_geta);
      exp_q.push_back(v_getb);
      exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, op));
      exp_q.push_back(v_wrreg);
    end else if (opc == 3'b101 && op == 2'b01) begin
      exp_q.push_back(v_geta);
      exp_q.push_back(v_getb);
      exp_q.push_back(v_cmps);
    end else if (opc == 3'b101 && op == 2'b11) begin
      exp_q.push_back(v_getb);
      exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b11));
      exp_q.push_back(v_wrreg);
    end
    exp_q.push_back(v_wait);
  endtask

  // Called at a negedge; each iteration crosses one posedge then compares.
  task automatic drain(input string name, input int drop_after, input int rst_at, input bit scramble);
    int i;
    logic [14:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s_c%0d", name, i), obs(), e);
      if (i == drop_after) bus.s = 1'b0;
      if (scramble && i == 0) begin
        bus.opcode = 3'b110;
        bus.op     = 2'b10;
      end
      if (i == rst_at) reset = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) reset = 1'b0;
      i++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] opc, input logic [1:0] op, input bit scramble);
    bus.opcode = opc;
    bus.op     = op;
    bus.s      = 1'b1;
    push_seq(opc, op);
    drain(name, 0, -1, scramble);
  endtask

  initial begin
    logic [2:0] ropc;
    logic [1:0] rop;
    reset      = 1'b1;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;
    @(negedge clk);
    check_eq("in_reset", obs(), v_wait);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) exp_q.push_back(v_wait);
    drain("idle", -1, -1, 1'b0);

    run("movi", 3'b110, 2'b10, 1'b0);
    run("add",  3'b101, 2'b00, 1'b0);
    run("and",  3'b101, 2'b10, 1'b0);
    run("cmp",  3'b101, 2'b01, 1'b0);
    run("mov",  3'b110, 2'b00, 1'b1);
    run("mvn",  3'b101, 2'b11, 1'b1);
    run("ill111", 3'b111, 2'b00, 1'b0);
    run("ill110_01", 3'b110, 2'b01, 1'b0);

    // s held high: one WAIT cycle, then a second instruction starts
    bus.opcode = 3'b110;
    bus.op     = 2'b10;
    bus.s      = 1'b1;
    push_seq(3'b110, 2'b10);
    push_seq(3'b110, 2'b10);
    drain("s_held", 3, -1, 1'b0);

    // reset while in EXEC of an ADD: abort, no write afterwards
    bus.opcode = 3'b101;
    bus.op     = 2'b00;
    bus.s      = 1'b1;
    exp_q.push_back(v_dec);
    exp_q.push_back(v_geta);
    exp_q.push_back(v_getb);
    exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00));
    repeat (3) exp_q.push_back(v_wait);
    drain("rst_exec", 0, 3, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ropc = 3'($urandom_range(4, 7));
      rop  = 2'($urandom_range(0, 3));
      run($sformatf("rnd%0d", k), ropc, rop, k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
